// File: rtl/regwb_arbiter.sv
// regwb_arbiter: two-source (ALU, LSU) register-file writeback arbiter.
// Round-robin arbitration on contention, one registered write stage,
// x0 write suppression, and pending/bypass detection for two read ports.
// Optional feature macro: REGWB_BYPASS_EN -- when defined, rs1_fwd/rs2_fwd
// carry the held write data on a pending match; otherwise they are tied to 0.
module regwb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_add,
  output logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_add,
  input  logic [AW-1:0]   rs2_add,
  output logic            rs1_pending,
  output logic            rs2_pending,
  output logic [XLEN-1:0] rs1_fwd,
  output logic [XLEN-1:0] rs2_fwd
);

  // Grant encoding for last_grant_r: 0 = ALU won last, 1 = LSU won last.
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  logic            last_grant_r;
  logic            wr_en_r;
  logic [AW-1:0]   wr_add_r;
  logic [XLEN-1:0] wr_data_r;

  logic            alu_gnt_s;
  logic            lsu_gnt_s;
  logic            xfer_s;
  logic [AW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;

  // Arbitration: single requester wins outright; on contention the source
  // that did not win last time is granted. Nothing is granted in reset.
  always_comb begin
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (!rst) begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end else if (alu_valid && lsu_valid) begin
      if (last_grant_r == GRANT_LSU) begin
        alu_gnt_s = 1'b1;
      end else begin
        lsu_gnt_s = 1'b1;
      end
    end else if (alu_valid) begin
      alu_gnt_s = 1'b1;
    end else if (lsu_valid) begin
      lsu_gnt_s = 1'b1;
    end else begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  // Select the winning request's destination and data.
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    if (lsu_gnt_s) begin
      sel_rd_s   = lsu_rd;
      sel_data_s = lsu_data;
    end else begin
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end
  end

  assign xfer_s    = alu_gnt_s | lsu_gnt_s;
  assign alu_ready = alu_gnt_s;
  assign lsu_ready = lsu_gnt_s;

  // Round-robin history: remember which source won the most recent transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= GRANT_LSU;
    end else if (xfer_s) begin
      last_grant_r <= lsu_gnt_s ? GRANT_LSU : GRANT_ALU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Output stage: one-cycle write pulse per accepted request; x0 writes are
  // accepted but never raise wr_en. Address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_r   <= 1'b0;
      wr_add_r  <= '0;
      wr_data_r <= '0;
    end else if (xfer_s) begin
      wr_en_r   <= (sel_rd_s != '0);
      wr_add_r  <= sel_rd_s;
      wr_data_r <= sel_data_s;
    end else begin
      wr_en_r   <= 1'b0;
      wr_add_r  <= wr_add_r;
      wr_data_r <= wr_data_r;
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_add  = wr_add_r;
  assign wr_data = wr_data_r;

  // A read is pending when it targets the register being written this cycle.
  always_comb begin
    rs1_pending = wr_en_r && (wr_add_r == rs1_add) && (rs1_add != '0);
    rs2_pending = wr_en_r && (wr_add_r == rs2_add) && (rs2_add != '0);
  end

`ifdef REGWB_BYPASS_EN
  // Bypass the in-flight write data to a matching read port.
  always_comb begin
    rs1_fwd = '0;
    rs2_fwd = '0;
    if (rs1_pending) begin
      rs1_fwd = wr_data_r;
    end else begin
      rs1_fwd = '0;
    end
    if (rs2_pending) begin
      rs2_fwd = wr_data_r;
    end else begin
      rs2_fwd = '0;
    end
  end
`else
  // Bypass disabled: forwarding outputs are constant zero.
  always_comb begin
    rs1_fwd = '0;
    rs2_fwd = '0;
  end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_regwb_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            wr_en;
  logic [AW-1:0]   wr_add;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   rs1_add;
  logic [AW-1:0]   rs2_add;
  logic            rs1_pending;
  logic            rs2_pending;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  regwb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .rs1_add(rs1_add), .rs2_add(rs2_add),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: who won the last contention-relevant transfer,
  // and the write the register file should be seeing this cycle.
  bit            m_lsu_last;
  bit            m_wr_en;
  logic [AW-1:0]   m_wr_add;
  logic [XLEN-1:0] m_wr_data;
  bit            bypass_on;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected pending/forward result for one read address.
  function automatic bit exp_pend(input logic [AW-1:0] a);
    return m_wr_en && (a == m_wr_add) && (a != 5'd0);
  endfunction

  // One clock of traffic. Called at a negedge; returns at the next negedge
  // after checking the registered write port.
  task automatic cycle(input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit exp_a, exp_l;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    rs1_add = r1; rs2_add = r2;
    #1;
    // Round robin: with both asking, the one that did not win last goes.
    exp_a = av && (!lv || m_lsu_last);
    exp_l = lv && !exp_a;
    chk("alu_ready", 64'(alu_ready), 64'(exp_a));
    chk("lsu_ready", 64'(lsu_ready), 64'(exp_l));
    chk("rs1_pending", 64'(rs1_pending), 64'(exp_pend(r1)));
    chk("rs2_pending", 64'(rs2_pending), 64'(exp_pend(r2)));
    chk("rs1_fwd", 64'(rs1_fwd), (bypass_on && exp_pend(r1)) ? 64'(m_wr_data) : 64'd0);
    chk("rs2_fwd", 64'(rs2_fwd), (bypass_on && exp_pend(r2)) ? 64'(m_wr_data) : 64'd0);
    @(posedge clk);
    if (exp_a || exp_l) begin
      m_wr_add   = exp_a ? ard : lrd;
      m_wr_data  = exp_a ? ad : ld;
      m_wr_en    = (m_wr_add != 5'd0);
      m_lsu_last = exp_l;
    end else begin
      m_wr_en = 1'b0;
    end
    @(negedge clk);
    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_add", 64'(wr_add), 64'(m_wr_add));
      chk("wr_data", 64'(wr_data), 64'(m_wr_data));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Apply reset at the current negedge and release it at the next one.
  task automatic do_reset();
    rst = 1'b0;
    m_wr_en = 1'b0; m_wr_add = 5'd0; m_wr_data = 32'd0; m_lsu_last = 1'b1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
`ifdef REGWB_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h5;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h7;
    rs1_add = 5'd0; rs2_add = 5'd0;
    m_wr_en = 1'b0; m_wr_add = 5'd0; m_wr_data = 32'd0; m_lsu_last = 1'b1;
    repeat (2) @(negedge clk);
    // Reset state: outputs clear, no grants even with requests present.
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_add", 64'(wr_add), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    rst = 1'b1;

    // Single ALU write rd5, then idle shows the pulse ends.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle();
    chk("single_hold_add", 64'(wr_add), 64'd5);

    // Contention after reset: ALU, LSU, ALU.
    do_reset();
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
    idle();

    // x0 filter on the LSU.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle();

    // Pending / bypass on rd7.
    cycle(1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);

    // Same-rd race after reset: 0xA then 0xB to rd9.
    do_reset();
    cycle(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9, 5'd0);
    chk("race_first", 64'(wr_data), 64'hA);
    cycle(1'b0, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9, 5'd0);
    chk("race_second", 64'(wr_data), 64'hB);
    idle();

    // Make LSU the last winner, then reset mid-operation after an ALU accept.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h10, 5'd0, 5'd0);
    cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    alu_valid = 1'b1; lsu_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_alu_ready", 64'(alu_ready), 64'd0);
    chk("midrst_lsu_ready", 64'(lsu_ready), 64'd0);
    chk("midrst_pending", 64'(rs1_pending), 64'd0);
    m_wr_en = 1'b0; m_wr_add = 5'd0; m_wr_data = 32'd0; m_lsu_last = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle();
    cycle(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 5'd12, 5'd13);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] ar, lr, r1, r2;
      ar = 5'($urandom_range(0, 31));
      lr = ($urandom_range(0, 3) == 0) ? ar : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? m_wr_add : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 1) == 0) ? ar : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), ar, $urandom(),
            1'($urandom_range(0, 1)), lr, $urandom(), r1, r2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
